r88_regfile: RTL

Rocket88 general register file and status-flag unit. Holds eight 8-bit registers R0–R7 and feeds the ALU's left and right operand inputs through registered read ports. Loads results from and drives values onto the shared internal data bus `intD`. Also captures the ALU carry out and bus-derived zero/negative flags, and supplies carry back to the ALU.

---
 rtl/r88_regfile.sv | 124 ++++++++++++
 1 files changed

// File: rtl/r88_regfile.sv
// Rocket88 register file: eight 8-bit registers, registered ALU operand ports,
// 16-bit pair increment/decrement and the C/Z/N status flags.
module r88_regfile (
    input  logic       sysClock,
    input  logic       sysResetN,
    inout  wire  [7:0] intD,
    input  logic [2:0] regLeftSel,
    input  logic [2:0] regRightSel,
    output logic [7:0] regLeft,
    output logic [7:0] regRight,
    input  logic       regWrite,
    input  logic [2:0] regWriteSel,
    input  logic       regOut,
    input  logic [2:0] regOutSel,
    input  logic       pairInc,
    input  logic       pairDec,
    input  logic [1:0] pairSel,
    output logic       pairZero,
    input  logic       aluCarry,
    input  logic       flagsLoad,
    input  logic       carrySet,
    input  logic       carryClr,
    output logic       flagC,
    output logic       flagZ,
    output logic       flagN
);

    logic [7:0]  regs_q [8];
    logic [7:0]  regs_d [8];
    logic [7:0]  left_q, left_d;
    logic [7:0]  right_q, right_d;
    logic        pair_zero_q, pair_zero_d;
    logic        flag_c_q, flag_c_d;
    logic        flag_z_q, flag_z_d;
    logic        flag_n_q, flag_n_d;

    logic [2:0]  pair_lo;
    logic [2:0]  pair_hi;
    logic [15:0] pair_cur;
    logic [15:0] pair_next;
    logic        pair_conflict;
    logic        pair_exec;
    logic        bus_drive;

    // Bus is released during reset so nothing fights the controller.
    assign bus_drive = regOut && sysResetN;
    assign intD      = bus_drive ? regs_q[regOutSel] : 8'bzzzz_zzzz;

    assign pair_lo       = {pairSel, 1'b0};
    assign pair_hi       = {pairSel, 1'b1};
    assign pair_cur      = {regs_q[pair_hi], regs_q[pair_lo]};
    assign pair_next     = pairInc ? (pair_cur + 16'd1) : (pair_cur - 16'd1);
    // A write into either byte of the selected pair wins over the pair op.
    assign pair_conflict = regWrite && (regWriteSel[2:1] == pairSel);
    assign pair_exec     = (pairInc ^ pairDec) && !pair_conflict;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end
        pair_zero_d = pair_zero_q;

        if (pair_exec) begin
            regs_d[pair_lo] = pair_next[7:0];
            regs_d[pair_hi] = pair_next[15:8];
            pair_zero_d     = (pair_next == 16'h0000);
        end

        if (regWrite) begin
            regs_d[regWriteSel] = intD;
        end

        // Operand ports see this edge's write or pair update.
        left_d  = regs_d[regLeftSel];
        right_d = regs_d[regRightSel];
    end

    always_comb begin
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        if (flagsLoad) begin
            flag_c_d = aluCarry;
            flag_z_d = (intD == 8'h00);
            flag_n_d = intD[7];
        end else if (carrySet) begin
            flag_c_d = 1'b1;
        end else if (carryClr) begin
            flag_c_d = 1'b0;
        end
    end

    always_ff @(posedge sysClock) begin
        if (!sysResetN) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 8'h00;
            end
            left_q      <= 8'h00;
            right_q     <= 8'h00;
            pair_zero_q <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            left_q      <= left_d;
            right_q     <= right_d;
            pair_zero_q <= pair_zero_d;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
        end
    end

    assign regLeft  = left_q;
    assign regRight = right_q;
    assign pairZero = pair_zero_q;
    assign flagC    = flag_c_q;
    assign flagZ    = flag_z_q;
    assign flagN    = flag_n_q;

endmodule
